// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
// operands consumed LSB-first, one bit per clock, done pulse on the last bit.
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fsm_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_sum;
    logic             bit_carry;
    logic             last_step;
    logic             load;

    // Handshake: start is a request sampled only in IDLE; an accepted start
    // is acknowledged by busy rising, and done pulses once when sum/cout are final.

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign bit_carry = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        load      = (state == IDLE) && start;
        fsm_state = state;
    end

    // sum doubles as the result shift register, so it only settles at done
    // and then holds until the next accepted start has shifted into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            sum   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= (state == RUN) && last_step;
            if (load) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                sum   <= {bit_sum, sum[WIDTH-1:1]};
                carry <= bit_carry;
                cnt   <= cnt + CW'(1);
                if (last_step) begin
                    cout <= bit_carry;
                end
            end
        end
    end

endmodule
